// File: rtl/ahb_slave_protocol_monitor.sv
// Passive AHB slave-side protocol monitor: data-phase FSM, burst tracker, sticky/pulse/counter reporting.
// Optional wait statistics (wait_total, wait_max) enabled by defining AHB_MON_WAIT_STATS_EN.
module ahb_slave_protocol_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  input  logic                  hreadyout,
  input  logic                  hresp,
  input  logic                  clr_sticky,
  output logic [5:0]            viol_pulse,
  output logic [5:0]            viol_sticky,
  output logic [2:0]            first_viol,
  output logic [CNT_WIDTH-1:0]  viol_count,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  irq
`ifdef AHB_MON_WAIT_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  wait_total,
  output logic [7:0]            wait_max
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    DP_IDLE     = 2'd0,
    DP_IDLE_CHK = 2'd1,
    DP_ACTIVE   = 2'd2,
    DP_ERR1     = 2'd3
  } dp_state_t;

  dp_state_t r_state, w_state_nxt;

  logic [WAIT_W-1:0]     r_wait;
  logic                  r_b_open, r_b_fixed, r_b_wrap, r_b_err;
  logic [4:0]            r_b_left, r_b_len;
  logic [2:0]            r_b_burst, r_b_size;
  logic [ADDR_WIDTH-1:0] r_b_addr;
  logic                  r_pend, r_p_write;
  logic [ADDR_WIDTH-1:0] r_p_addr;
  logic [2:0]            r_p_size, r_p_burst;
  logic [1:0]            r_p_trans;
  logic [5:0]            r_sticky;
  logic [2:0]            r_first;
  logic [CNT_WIDTH-1:0]  r_vcnt, r_xcnt;
  logic                  r_irq;

  logic                  w_acc, w_act, w_nonseq, w_seq, w_idle_acc, w_dp, w_b_err, w_left_pend;
  logic [ADDR_WIDTH-1:0] w_inc, w_bound, w_incr_addr, w_exp_addr;
  logic [5:0]            w_viol, w_sticky_nxt;
  logic [2:0]            w_first_base, w_first_nxt;

  function automatic logic [4:0] burst_len(input logic [2:0] b);
    case (b[2:1])
      2'd1:    return 5'd4;
      2'd2:    return 5'd8;
      2'd3:    return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

  function automatic logic [2:0] lowest_idx(input logic [5:0] v);
    logic [2:0] idx;
    idx = 3'd7;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 6; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a, input logic [2:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH + 1)'(b);
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  // Transfer decode, expected burst address, protocol checks and next data-phase state.
  always_comb begin
    w_acc       = hselx & hready;
    w_act       = w_acc & htrans[1];
    w_nonseq    = w_acc & (htrans == 2'd2);
    w_seq       = w_acc & (htrans == 2'd3);
    w_idle_acc  = w_acc & (htrans == 2'd0);
    w_dp        = (r_state == DP_ACTIVE) | (r_state == DP_ERR1);
    // An ERROR seen during the burst excuses an early termination.
    w_b_err     = r_b_err | (hresp & w_dp);
    w_left_pend = r_b_open & r_b_fixed & (r_b_left != 5'd0) & !w_b_err;

    w_inc       = ONE_A << r_b_size;
    w_bound     = ADDR_WIDTH'(r_b_len) << r_b_size;
    w_incr_addr = r_b_addr + w_inc;
    if (r_b_wrap) begin
      w_exp_addr = (r_b_addr & ~(w_bound - ONE_A)) | (w_incr_addr & (w_bound - ONE_A));
    end else begin
      w_exp_addr = w_incr_addr;
    end

    w_viol    = 6'd0;
    w_viol[0] = w_act & ((32'd8 << hsize) > 32'(DATA_WIDTH));
    w_viol[1] = (r_state == DP_ACTIVE) & !hreadyout & ((32'(r_wait) + 32'd1) == 32'(MAX_WAIT));
    w_viol[2] = ((r_state == DP_ACTIVE) & hresp & hreadyout) | ((r_state == DP_ERR1) & !hresp);
    w_viol[3] = (r_state == DP_IDLE_CHK) & (!hreadyout | hresp);
    w_viol[4] = r_pend & ((haddr != r_p_addr) | (hwrite != r_p_write) | (hsize != r_p_size) |
                          (hburst != r_p_burst) | (htrans != r_p_trans));
    w_viol[5] = (w_seq & (!r_b_open | (haddr != w_exp_addr) | (hburst != r_b_burst) |
                          (hsize != r_b_size) | (r_b_fixed & (r_b_left == 5'd0)))) |
                ((w_nonseq | w_idle_acc) & w_left_pend);

    w_state_nxt = DP_IDLE;
    case (r_state)
      DP_ACTIVE: begin
        if (hresp & !hreadyout) begin
          w_state_nxt = DP_ERR1;
        end else if (hreadyout) begin
          w_state_nxt = w_act ? DP_ACTIVE : (w_acc ? DP_IDLE_CHK : DP_IDLE);
        end else begin
          w_state_nxt = DP_ACTIVE;
        end
      end
      DP_ERR1: begin
        if (hreadyout) begin
          w_state_nxt = w_act ? DP_ACTIVE : (w_acc ? DP_IDLE_CHK : DP_IDLE);
        end else begin
          w_state_nxt = DP_ERR1;
        end
      end
      default: begin
        w_state_nxt = w_act ? DP_ACTIVE : (w_acc ? DP_IDLE_CHK : DP_IDLE);
      end
    endcase

    // Clear drops old bits only; a pulse in the same cycle is still recorded.
    w_sticky_nxt = (clr_sticky ? 6'd0 : r_sticky) | w_viol;
    w_first_base = clr_sticky ? 3'd7 : r_first;
    if ((w_first_base == 3'd7) && (w_viol != 6'd0)) begin
      w_first_nxt = lowest_idx(w_viol);
    end else begin
      w_first_nxt = w_first_base;
    end

    viol_pulse = hreset ? 6'd0 : w_viol;
  end

  // Data-phase FSM, wait counter and stability snapshot.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state   <= DP_IDLE;
      r_wait    <= '0;
      r_pend    <= 1'b0;
      r_p_addr  <= '0;
      r_p_write <= 1'b0;
      r_p_size  <= 3'd0;
      r_p_burst <= 3'd0;
      r_p_trans <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == DP_ACTIVE) && !hreadyout) begin
        r_wait <= (r_wait == WAIT_W'(MAX_WAIT)) ? r_wait : r_wait + WAIT_W'(1);
      end else begin
        r_wait <= '0;
      end
      r_pend    <= hselx & !hready & htrans[1];
      r_p_addr  <= haddr;
      r_p_write <= hwrite;
      r_p_size  <= hsize;
      r_p_burst <= hburst;
      r_p_trans <= htrans;
    end
  end

  // Burst tracker.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_b_open  <= 1'b0;
      r_b_fixed <= 1'b0;
      r_b_wrap  <= 1'b0;
      r_b_err   <= 1'b0;
      r_b_left  <= 5'd0;
      r_b_len   <= 5'd1;
      r_b_burst <= 3'd0;
      r_b_size  <= 3'd0;
      r_b_addr  <= '0;
    end else if (w_nonseq) begin
      r_b_open  <= (hburst != 3'd0);
      r_b_fixed <= (hburst[2:1] != 2'd0);
      r_b_wrap  <= (hburst[2:1] != 2'd0) & !hburst[0];
      r_b_err   <= 1'b0;
      r_b_len   <= burst_len(hburst);
      r_b_left  <= burst_len(hburst) - 5'd1;
      r_b_burst <= hburst;
      r_b_size  <= hsize;
      r_b_addr  <= haddr;
    end else if (w_seq) begin
      r_b_err  <= w_b_err;
      r_b_addr <= haddr;
      r_b_left <= (r_b_left != 5'd0) ? r_b_left - 5'd1 : r_b_left;
    end else if (w_idle_acc) begin
      r_b_open <= 1'b0;
      r_b_err  <= w_b_err;
    end else begin
      r_b_err <= w_b_err;
    end
  end

  // Sticky flags, first violation index and saturating counters.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_sticky <= 6'd0;
      r_first  <= 3'd7;
      r_vcnt   <= '0;
      r_xcnt   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sticky <= w_sticky_nxt;
      r_first  <= w_first_nxt;
      r_vcnt   <= sat_add(r_vcnt, popcount6(w_viol));
      r_xcnt   <= sat_add(r_xcnt, {2'b00, w_act});
      r_irq    <= |w_sticky_nxt;
    end
  end

  assign viol_sticky = r_sticky;
  assign first_viol  = r_first;
  assign viol_count  = r_vcnt;
  assign xfer_count  = r_xcnt;
  assign irq         = r_irq;

`ifdef AHB_MON_WAIT_STATS_EN
  logic [7:0]           r_pw, r_wmax;
  logic [CNT_WIDTH-1:0] r_wtot;
  logic                 w_dp_wait;
  logic [7:0]           w_pw_inc;

  always_comb begin
    w_dp_wait = w_dp & !hreadyout;
    w_pw_inc  = (r_pw == 8'hFF) ? r_pw : r_pw + 8'd1;
  end

  // Per-phase wait length, running total and longest phase.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_pw   <= 8'd0;
      r_wmax <= 8'd0;
      r_wtot <= '0;
    end else begin
      r_pw <= w_dp_wait ? w_pw_inc : 8'd0;
      if (clr_sticky) begin
        r_wmax <= 8'd0;
        r_wtot <= '0;
      end else if (w_dp_wait) begin
        r_wtot <= sat_add(r_wtot, 3'd1);
        r_wmax <= (w_pw_inc > r_wmax) ? w_pw_inc : r_wmax;
      end else begin
        r_wmax <= r_wmax;
        r_wtot <= r_wtot;
      end
    end
  end

  assign wait_total = r_wtot;
  assign wait_max   = r_wmax;
`endif

endmodule
